imu_read_sequencer: RTL and testbench
=====================================

# imu_read_sequencer

Transaction sequencer sitting above the byte-level SPI master for the MPU-6050/ICM-20948 IMU. After reset it confirms device identity via WHO_AM_I, then at a fixed sample rate issues 12-byte burst reads from ACCEL_XOUT and extracts accel X/Y and gyro X/Y. It emits 64-bit motion deltas (current minus previous) to the downstream delta path, and reports presence, failure and overrun status.

## Interface
- SAMPLE_DIV, 270_000: clk cycles per sample tick (100 Hz at 27 MHz); ≥ 2.
- DETECT_TRIES, 16: WHO_AM_I attempts before declaring failure; 1..255.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  synchronous, active-low reset.
- byte_start  out  1  one-cycle request to the byte engine to shift byte_tx.
- byte_tx  out  8  byte to transmit; valid while byte_start is high.
- byte_last  out  1  deassert CS after this byte; sampled with byte_start.
- byte_busy  in  1  byte engine busy.
- byte_done  in  1  one-cycle pulse: byte finished, byte_rx valid.
- byte_rx  in  8  received byte.
- imu_present  out  1  level: identity confirmed.
- imu_failed  out  1  level: detection exhausted; sticky until reset.
- sample_valid  out  1  one-cycle pulse: sample_data updated.
- sample_data  out  64  {d_accel_x, d_accel_y, d_gyro_x, d_gyro_y}, 16 bits each.
- overrun_cnt  out  8  dropped ticks; saturates at 255.

## Operation
- Reset: all outputs 0, including byte_tx, sample_data and overrun_cnt. The state is ID_CMD, the tick counter is 0, the try counter is 0, the baseline is invalid.
- Byte issue rule:
  - byte_start is asserted only when byte_busy=0 and no byte is outstanding.
  - Exactly one byte is outstanding until byte_done arrives.
  - byte_done received with no byte outstanding is ignored.
- ID_CMD: issue 0xF5 (0x75|0x80) with byte_last=0. Go to ID_READ.
- ID_READ: issue 0x00 with byte_last=1. Go to ID_CHECK.
- ID_CHECK: evaluate byte_rx of the second byte.
  - 0x68 or 0xEA: set imu_present=1 and go to WAIT_TICK.
  - Otherwise: increment the try counter. If tries == DETECT_TRIES, set imu_failed=1 and go to FAIL; else go to ID_CMD.
- FAIL: terminal; no bytes are issued and imu_present stays 0.
- WAIT_TICK: on a tick, go to BURST_CMD.
- BURST_CMD: issue 0xBB (0x3B|0x80) with byte_last=0.
- BURST_DATA: issue 12 bytes of 0x00. byte_last=1 only on the 12th byte. Capture byte_rx by index:
  - bytes 0-1 → ax, big-endian
  - bytes 2-3 → ay
  - bytes 8-9 → gx
  - bytes 10-11 → gy
  - all other bytes are discarded.
- UPDATE:
  - Delta = new − previous per field, modulo 2^16 (wrap, no saturation).
  - If the baseline is invalid: store the new values as the baseline, set baseline valid, emit no sample_valid.
  - Otherwise: drive sample_data, pulse sample_valid, and store the new values as the baseline.
  - Return to WAIT_TICK.

## Timing
- Tick counter starts at reset release, counts 0..SAMPLE_DIV−1 and wraps. Tick = 1 cycle at count SAMPLE_DIV−1. It runs in every state.
- A tick in WAIT_TICK: byte_start for 0xBB asserts 1 cycle later (assuming byte_busy=0).
- A tick in any other state except FAIL: the tick is dropped and overrun_cnt increments, holding at 255. Ticks during detection also count.
- The next byte_start follows ≥1 cycle after byte_done, gated by byte_busy=0.
- sample_valid pulses 1 cycle after the 12th data byte's byte_done. sample_data holds until the next update.
- imu_present / imu_failed assert 1 cycle after the ID-byte byte_done.
- A reset assertion mid-burst aborts on the next edge: partial capture is discarded and the baseline is invalidated. The byte engine shares rst_n, so no CS cleanup is needed.
- Tick and byte_done in the same cycle: both are processed, and the tick counts as an overrun.

## Structure
- Package imu_seq_pkg holds:
  - REG_WHO_AM_I=0x75, REG_ACCEL_XOUT=0x3B, SPI_READ_BIT=0x80
  - ID_MPU=0x68, ID_ICM=0xEA
  - BURST_BYTES=12
  - the state enum (ID_CMD, ID_READ, ID_CHECK, WAIT_TICK, BURST_CMD, BURST_DATA, UPDATE, FAIL).
- One sub-module, imu_sample_timer: tick counter with parameter SAMPLE_DIV, output tick.
- Field capture, delta subtraction and the byte-issue FSM stay in the top module.

## Test plan
- Engine model returns 0x68 on the ID byte → exactly 2 bytes issued (0xF5, then 0x00 with last=1); imu_present=1 one cycle after done; imu_failed=0.
- Engine model always returns 0x00 with DETECT_TRIES=3 → 6 bytes issued, imu_failed=1, then no further byte_start for ≥3 ticks.
- SAMPLE_DIV=200, ID 0xEA, first burst ax=0x0100 and second burst ax=0x00F0 (others constant) → first burst gives no sample_valid; second gives sample_data[63:48]=0xFFF0 with other fields 0; 13 bytes per burst, last only on byte 13.
- Wrap: previous gy=0xFFFF, new gy=0x0001 → sample_data[15:0]=0x0002.
- Engine model holds byte_busy high for 3 ticks → overrun_cnt=3; 300 ticks → overrun_cnt=255.
- rst_n low for one cycle during byte 6 of a burst → all outputs 0; detection restarts with 0xF5; the next two bursts produce exactly one sample_valid.

Source files
------------

// File: rtl/imu_read_sequencer_pkg.sv
// Shared constants, state encoding and field helpers for the IMU read sequencer.
package imu_seq_pkg;

  localparam logic [7:0] REG_WHO_AM_I   = 8'h75;
  localparam logic [7:0] REG_ACCEL_XOUT = 8'h3B;
  localparam logic [7:0] SPI_READ_BIT   = 8'h80;
  localparam logic [7:0] ID_MPU         = 8'h68;
  localparam logic [7:0] ID_ICM         = 8'hEA;
  localparam int         BURST_BYTES    = 12;

  typedef enum logic [2:0] {
    ID_CMD, ID_READ, ID_CHECK, WAIT_TICK, BURST_CMD, BURST_DATA, UPDATE, FAIL
  } seq_state_e;

  // Field order matches the sample_data packing, ax in the MSBs.
  typedef struct packed {
    logic [15:0] ax;
    logic [15:0] ay;
    logic [15:0] gx;
    logic [15:0] gy;
  } imu_fields_t;

  function automatic imu_fields_t field_delta(imu_fields_t now, imu_fields_t prev);
    imu_fields_t d;
    d.ax = now.ax - prev.ax;
    d.ay = now.ay - prev.ay;
    d.gx = now.gx - prev.gx;
    d.gy = now.gy - prev.gy;
    return d;
  endfunction

endpackage

// File: rtl/imu_read_sequencer_if.sv
// Byte-level handshake between the sequencer and the SPI byte engine.
interface imu_byte_if;
  logic       byte_start;
  logic [7:0] byte_tx;
  logic       byte_last;
  logic       byte_busy;
  logic       byte_done;
  logic [7:0] byte_rx;

  modport master (output byte_start, byte_tx, byte_last,
                  input  byte_busy, byte_done, byte_rx);
  modport slave  (input  byte_start, byte_tx, byte_last,
                  output byte_busy, byte_done, byte_rx);
endinterface

// File: rtl/imu_read_sequencer_timer.sv
// Free-running sample tick: one-cycle pulse every SAMPLE_DIV clocks from reset release.
module imu_sample_timer #(
  parameter int SAMPLE_DIV = 270_000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);
  localparam int              CW   = $clog2(SAMPLE_DIV);
  localparam logic [CW-1:0]   LAST = CW'(SAMPLE_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n)           cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

  assign tick = (cnt == LAST);
endmodule

// File: rtl/imu_read_sequencer.sv
// WHO_AM_I detection then periodic 12-byte bursts; emits per-field deltas between bursts.
module imu_read_sequencer
  import imu_seq_pkg::*;
#(
  parameter int SAMPLE_DIV   = 270_000,
  parameter int DETECT_TRIES = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  imu_byte_if.master  bus,
  output logic        imu_present,
  output logic        imu_failed,
  output logic        sample_valid,
  output logic [63:0] sample_data,
  output logic [7:0]  overrun_cnt
);
  localparam logic [3:0] BURST_N    = 4'(BURST_BYTES);
  localparam logic [7:0] TRIES_LAST = 8'(DETECT_TRIES);

  seq_state_e  state, state_n;
  logic        tick;
  logic        pend;
  logic [7:0]  tries;
  logic [3:0]  tx_idx;
  logic [3:0]  rx_idx;
  imu_fields_t cur, cur_cap, base;
  logic        base_vld;
  logic        start, last;
  logic [7:0]  tx;
  logic        can_issue, rx_ok, id_match;

  imu_sample_timer #(.SAMPLE_DIV(SAMPLE_DIV)) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // rst_n gates issue so byte_start is low for the whole reset cycle.
  assign can_issue = rst_n && !bus.byte_busy && !pend;
  assign rx_ok     = pend && bus.byte_done;
  assign id_match  = (bus.byte_rx == ID_MPU) || (bus.byte_rx == ID_ICM);
  assign rx_idx    = tx_idx - 4'd1;

  assign bus.byte_start = start;
  assign bus.byte_tx    = tx;
  assign bus.byte_last  = last;

  always_comb begin
    state_n = state;
    start   = 1'b0;
    tx      = 8'h00;
    last    = 1'b0;
    case (state)
      ID_CMD: if (can_issue) begin
        start   = 1'b1;
        tx      = REG_WHO_AM_I | SPI_READ_BIT;
        state_n = ID_READ;
      end
      ID_READ: if (can_issue) begin
        start   = 1'b1;
        last    = 1'b1;
        state_n = ID_CHECK;
      end
      ID_CHECK: if (rx_ok) begin
        if (id_match)                      state_n = WAIT_TICK;
        else if (tries + 8'd1 == TRIES_LAST) state_n = FAIL;
        else                               state_n = ID_CMD;
      end
      WAIT_TICK: if (tick) state_n = BURST_CMD;
      BURST_CMD: if (can_issue) begin
        start   = 1'b1;
        tx      = REG_ACCEL_XOUT | SPI_READ_BIT;
        state_n = BURST_DATA;
      end
      BURST_DATA: begin
        if (rx_ok && tx_idx == BURST_N) state_n = UPDATE;
        else if (can_issue && tx_idx < BURST_N) begin
          start = 1'b1;
          last  = (tx_idx == BURST_N - 4'd1);
        end
      end
      UPDATE:  state_n = WAIT_TICK;
      FAIL:    state_n = FAIL;
      default: state_n = ID_CMD;
    endcase
  end

  // tx_idx counts issued data bytes, so a done with tx_idx==0 is the command byte.
  always_comb begin
    cur_cap = cur;
    if (state == BURST_DATA && rx_ok && tx_idx != 4'd0) begin
      case (rx_idx)
        4'd0:    cur_cap.ax[15:8] = bus.byte_rx;
        4'd1:    cur_cap.ax[7:0]  = bus.byte_rx;
        4'd2:    cur_cap.ay[15:8] = bus.byte_rx;
        4'd3:    cur_cap.ay[7:0]  = bus.byte_rx;
        4'd8:    cur_cap.gx[15:8] = bus.byte_rx;
        4'd9:    cur_cap.gx[7:0]  = bus.byte_rx;
        4'd10:   cur_cap.gy[15:8] = bus.byte_rx;
        4'd11:   cur_cap.gy[7:0]  = bus.byte_rx;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= ID_CMD;
      pend         <= 1'b0;
      tries        <= 8'd0;
      tx_idx       <= 4'd0;
      cur          <= '0;
      base         <= '0;
      base_vld     <= 1'b0;
      imu_present  <= 1'b0;
      imu_failed   <= 1'b0;
      sample_valid <= 1'b0;
      sample_data  <= 64'd0;
      overrun_cnt  <= 8'd0;
    end else begin
      state        <= state_n;
      sample_valid <= 1'b0;
      cur          <= cur_cap;

      if (start)              pend <= 1'b1;
      else if (bus.byte_done) pend <= 1'b0;

      if (tick && state != WAIT_TICK && state != FAIL && overrun_cnt != 8'hFF)
        overrun_cnt <= overrun_cnt + 8'd1;

      if (state == ID_CHECK && rx_ok) begin
        if (id_match) imu_present <= 1'b1;
        else begin
          tries <= tries + 8'd1;
          if (tries + 8'd1 == TRIES_LAST) imu_failed <= 1'b1;
        end
      end

      if (state == BURST_CMD) tx_idx <= 4'd0;
      if (state == BURST_DATA && start) tx_idx <= tx_idx + 4'd1;

      // Delta is formed on the final byte so sample_valid lands the next cycle.
      if (state == BURST_DATA && rx_ok && tx_idx == BURST_N) begin
        sample_valid <= base_vld;
        if (base_vld) sample_data <= field_delta(cur_cap, base);
      end

      if (state == UPDATE) begin
        base     <= cur;
        base_vld <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_imu_read_sequencer.sv
// Randomized bench: byte-engine/device model feeds the DUT, a scoreboard checks the deltas.
module tb_imu_read_sequencer;
  localparam int DIV   = 200;
  localparam int TRIES = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imu_present, imu_failed, sample_valid;
  logic [63:0] sample_data;
  logic [7:0]  overrun_cnt;

  always #5 clk = ~clk;

  imu_byte_if bus ();

  imu_read_sequencer #(.SAMPLE_DIV(DIV), .DETECT_TRIES(TRIES)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .imu_present  (imu_present),
    .imu_failed   (imu_failed),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .overrun_cnt  (overrun_cnt)
  );

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Device / engine model state
  bit          dev_busy, force_busy, accepted, dev_pend, id_chk, sv_chk, exp_sv;
  bit          have_prev, exp_present, exp_failed;
  int          lat, frame_pos, byte_cnt, burst_cnt, sv_cnt, tries, pend_kind;
  logic [7:0]  cmd, dev_id, resp;
  logic [95:0] cur_burst, prev_burst;
  logic [95:0] dirq[$];
  logic [63:0] sbq[$];

  function automatic logic [63:0] bdelta(logic [95:0] n, logic [95:0] p);
    return {16'(n[95:80] - p[95:80]), 16'(n[79:64] - p[79:64]),
            16'(n[31:16] - p[31:16]), 16'(n[15:0]  - p[15:0])};
  endfunction

  task automatic on_start();
    int flen;
    chk("start_gate", {62'd0, bus.byte_busy, dev_pend}, 64'd0);
    byte_cnt++;
    dev_pend  = 1'b1;
    accepted  = 1'b1;
    pend_kind = 0;
    if (frame_pos == 0) begin
      chk("cmd_tx", bus.byte_tx, exp_present ? 8'hBB : 8'hF5);
      chk("cmd_last", bus.byte_last, 0);
      cmd       = bus.byte_tx;
      frame_pos = 1;
      resp      = 8'h00;
      if (cmd == 8'hBB)
        cur_burst = (dirq.size() > 0) ? dirq.pop_front() : {$urandom, $urandom, $urandom};
    end else begin
      flen = (cmd == 8'hF5) ? 1 : 12;
      chk("data_tx", bus.byte_tx, 0);
      chk("data_last", bus.byte_last, (frame_pos == flen) ? 1 : 0);
      resp = (cmd == 8'hF5) ? dev_id : cur_burst[95 - 8*(frame_pos-1) -: 8];
      if (frame_pos == flen) begin
        pend_kind = (cmd == 8'hF5) ? 1 : 2;
        frame_pos = 0;
      end else frame_pos++;
    end
  endtask

  task automatic on_done();
    if (pend_kind == 1) begin
      tries++;
      exp_present = (dev_id == 8'h68) || (dev_id == 8'hEA);
      if (!exp_present && tries == TRIES) exp_failed = 1'b1;
      id_chk = 1'b1;
    end else if (pend_kind == 2) begin
      burst_cnt++;
      exp_sv = have_prev;
      if (have_prev) sbq.push_back(bdelta(cur_burst, prev_burst));
      prev_burst = cur_burst;
      have_prev  = 1'b1;
      sv_chk     = 1'b1;
    end
  endtask

  initial begin
    bus.byte_busy = 1'b0; bus.byte_done = 1'b0; bus.byte_rx = 8'h00;
    forever begin
      @(negedge clk); #1;
      if (!rst_n) begin
        dev_busy = 0; accepted = 0; dev_pend = 0; id_chk = 0; sv_chk = 0;
        have_prev = 0; exp_present = 0; exp_failed = 0;
        lat = 0; frame_pos = 0; byte_cnt = 0; tries = 0; pend_kind = 0;
        sbq.delete();
        bus.byte_done = 1'b0; bus.byte_busy = 1'b0;
      end else begin
        if (id_chk) begin
          chk("present", imu_present, exp_present);
          chk("failed", imu_failed, exp_failed);
          id_chk = 0;
        end
        if (sv_chk) begin
          chk("sv_timing", sample_valid, exp_sv);
          sv_chk = 0;
        end
        if (bus.byte_done) dev_pend = 0;
        bus.byte_done = 1'b0;
        if (accepted) begin
          accepted = 0;
          dev_busy = 1;
          lat = $urandom_range(1, 3);
        end else if (lat > 0) begin
          lat--;
          if (lat == 0) begin
            dev_busy = 0;
            bus.byte_done = 1'b1;
            bus.byte_rx = resp;
            on_done();
          end
        end
        bus.byte_busy = dev_busy || force_busy;
        #1;
        if (bus.byte_start) on_start();
      end
    end
  end

  // Scoreboard monitor
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk); #3;
      if (rst_n && sample_valid) begin
        sv_cnt++;
        if (sbq.size() == 0) chk("sv_unexpected", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("sample_data", sample_data, e);
        end
      end
    end
  end

  function automatic bit cond(int sel, int tgt);
    case (sel)
      0:       return exp_failed;
      1:       return exp_present;
      2:       return burst_cnt >= tgt;
      default: return (cmd == 8'hBB) && (frame_pos == 6);
    endcase
  endfunction

  task automatic wait_cond(int sel, int tgt, int limit, string nm);
    int i;
    for (i = 0; i < limit && !cond(sel, tgt); i++) @(negedge clk);
    chk(nm, cond(sel, tgt), 1);
  endtask

  task automatic check_zero(string nm);
    chk({nm, "_ctl"}, {bus.byte_start, bus.byte_tx, bus.byte_last, imu_present,
                       imu_failed, sample_valid, overrun_cnt}, 0);
    chk({nm, "_data"}, sample_data, 0);
  endtask

  task automatic run_bursts(int n);
    wait_cond(2, burst_cnt + n, n * 3 * DIV, "burst_timeout");
    repeat (2) @(negedge clk);
  endtask

  localparam logic [15:0] AY0 = 16'h1234, GX0 = 16'h5678, GY0 = 16'h9ABC;

  initial begin
    int sv0;
    dev_id = 8'h00; force_busy = 0;
    repeat (3) @(negedge clk);
    check_zero("rst0");
    rst_n = 1'b1;

    // Detection never matches: three tries, then silence.
    wait_cond(0, 0, 2000, "fail_timeout");
    repeat (3 * DIV + 5) @(negedge clk);
    chk("fail_bytes", byte_cnt, 6);
    chk("fail_flag", imu_failed, 1);
    chk("fail_present", imu_present, 0);
    chk("fail_overrun", overrun_cnt, 0);

    rst_n = 1'b0; dev_id = 8'h68;
    @(negedge clk);
    check_zero("rst1");
    rst_n = 1'b1;
    wait_cond(1, 0, 200, "present_timeout");
    repeat (2) @(negedge clk);
    chk("id_bytes", byte_cnt, 2);

    // Stall the engine across ticks.
    force_busy = 1;
    repeat (4 * DIV) @(negedge clk);
    chk("overrun3", overrun_cnt, 3);
    repeat (296 * DIV) @(negedge clk);
    chk("overrun_sat", overrun_cnt, 255);

    dirq.push_back({16'h0100, AY0, $urandom, GX0, GY0});
    dirq.push_back({16'h00F0, AY0, $urandom, GX0, GY0});
    sv0 = sv_cnt;
    force_busy = 0;
    run_bursts(2);
    chk("ax_sv_count", sv_cnt - sv0, 1);
    chk("ax_delta", sample_data, 64'hFFF0_0000_0000_0000);

    dirq.push_back({16'h00F0, AY0, $urandom, GX0, 16'hFFFF});
    dirq.push_back({16'h00F0, AY0, $urandom, GX0, 16'h0001});
    sv0 = sv_cnt;
    run_bursts(2);
    chk("wrap_sv_count", sv_cnt - sv0, 2);
    chk("gy_wrap", sample_data, 64'h0000_0000_0000_0002);

    run_bursts(6);

    // Reset in the middle of a burst.
    wait_cond(3, 0, 3 * DIV, "midburst_timeout");
    rst_n = 1'b0;
    @(negedge clk);
    check_zero("rst_mid");
    rst_n = 1'b1;
    wait_cond(1, 0, 200, "present2_timeout");
    sv0 = sv_cnt;
    run_bursts(2);
    chk("post_rst_sv", sv_cnt - sv0, 1);
    chk("sb_empty", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
